// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter: FSM encoding,
// default memory depth and the word-address validity check.
package imem_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int IMEM_AW = 6;

  // A byte address is usable when it is word aligned and its word index fits in aw bits.
  function automatic logic addr_is_valid(input logic [31:0] addr, input int aw);
    logic [31:0] upper;
    upper = addr >> (aw + 2);
    return (addr[1:0] == 2'b00) && (upper == 32'd0);
  endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Combinational alignment/range check of a byte address against the
// instruction memory, producing a valid flag and the word index.
module imem_addr_check
  import imem_arbiter_pkg::*;
#(
  parameter int AW = IMEM_AW
) (
  input  logic [31:0]   addr,
  output logic          valid,
  output logic [AW-1:0] word_idx
);

  assign valid    = addr_is_valid(addr, AW);
  assign word_idx = addr[AW+1:2];

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction memory between the fetch unit (reads)
// and a loader (writes), with bounded loader bursts and an exclusive lock mode.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int AW        = IMEM_AW,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  input  logic          ld_lock,
  output logic          ld_gnt,
  output logic          locked,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          rerr_q, rerr_d;

  logic          fetch_ok, ld_ok;
  logic [AW-1:0] fetch_idx, ld_idx;
  logic          fetch_gnt_c, ld_gnt_c;
  logic          rd_en, wr_en;

  imem_addr_check #(.AW(AW)) u_fetch_chk (
    .addr     (fetch_addr),
    .valid    (fetch_ok),
    .word_idx (fetch_idx)
  );

  imem_addr_check #(.AW(AW)) u_ld_chk (
    .addr     (ld_addr),
    .valid    (ld_ok),
    .word_idx (ld_idx)
  );

  // A pending lock request blocks new fetches, so any read still in flight
  // delivers its rvalid in the same cycle the FSM moves to LOCKED.
  always_comb begin
    fetch_gnt_c = 1'b0;
    ld_gnt_c    = 1'b0;
    if (!reset) begin
      if (state_q == ARB) begin
        fetch_gnt_c = fetch_req && !ld_lock && (!ld_req || (burst_cnt_q == BURST_MAX));
        ld_gnt_c    = ld_req && !fetch_gnt_c;
      end else begin
        ld_gnt_c    = ld_req;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = '0;
    if (ld_gnt_c && fetch_req) begin
      burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 1'b1;
    end
    if (state_q == ARB) begin
      if (ld_lock) begin
        state_d = LOCKED;
      end
    end else if (!ld_lock) begin
      state_d     = ARB;
      burst_cnt_d = '0;
    end
    rvalid_d = fetch_gnt_c;
    rerr_d   = fetch_gnt_c && !fetch_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      burst_cnt_q <= '0;
      rvalid_q    <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
      rerr_q      <= rerr_d;
    end
  end

  assign rd_en     = fetch_gnt_c && fetch_ok;
  assign wr_en     = ld_gnt_c && ld_ok;

  assign fetch_gnt = fetch_gnt_c;
  assign ld_gnt    = ld_gnt_c;
  assign mem_en    = rd_en || wr_en;
  assign mem_we    = wr_en;
  assign mem_addr  = wr_en ? ld_idx : (rd_en ? fetch_idx : '0);
  assign mem_wdata = wr_en ? ld_wdata : 32'd0;

  assign fetch_rvalid = rvalid_q && !reset;
  assign fetch_err    = fetch_rvalid && rerr_q;
  assign fetch_rdata  = (fetch_rvalid && !rerr_q) ? mem_rdata : 32'd0;
  assign locked       = (state_q == LOCKED) && !reset;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural 64-word
// synchronous memory attached to the memory-side ports.
module tb_imem_arbiter;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          fetch_err;
  logic          ld_req;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_lock;
  logic          ld_gnt;
  logic          locked;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   mem [64];

  int checks = 0;
  int errors = 0;

  imem_arbiter #(.AW(AW), .MAX_BURST(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_err    (fetch_err),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_lock      (ld_lock),
    .ld_gnt       (ld_gnt),
    .locked       (locked),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // One-cycle-latency synchronous RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic apply_stimulus(input logic rst, input logic fr, input logic [31:0] fa,
                                input logic lr, input logic [31:0] la, input logic [31:0] lw,
                                input logic lk);
    @(posedge clk);
    #1;
    reset      = rst;
    fetch_req  = fr;
    fetch_addr = fa;
    ld_req     = lr;
    ld_addr    = la;
    ld_wdata   = lw;
    ld_lock    = lk;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 32'h1, 1'b1);
      checks++;
      if ({fetch_gnt, ld_gnt, mem_en, mem_we, fetch_rvalid, fetch_err, locked} !== 7'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctrl: gnt/ld/en/we/rv/err/lk=%b expected 0000000",
                 {fetch_gnt, ld_gnt, mem_en, mem_we, fetch_rvalid, fetch_err, locked});
      end
      checks++;
      if ({mem_addr, mem_wdata, fetch_rdata} !== 70'd0) begin
        errors++;
        $display("[TB] FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0",
                 mem_addr, mem_wdata, fetch_rdata);
      end
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_single_fetch;
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({fetch_gnt, ld_gnt, mem_en, mem_we} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL single_gnt: gnt/ld/en/we=%b expected 1010",
               {fetch_gnt, ld_gnt, mem_en, mem_we});
    end
    checks++;
    if (mem_addr !== 6'd4) begin
      errors++;
      $display("[TB] FAIL single_addr: mem_addr=%0d expected 4", mem_addr);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({fetch_rvalid, fetch_err} !== 2'b10 || fetch_rdata !== 32'h00500093) begin
      errors++;
      $display("[TB] FAIL single_rdata: rv=%b err=%b rdata=%h expected 1 0 00500093",
               fetch_rvalid, fetch_err, fetch_rdata);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL single_pulse: rv=%b rdata=%h expected 0 0", fetch_rvalid, fetch_rdata);
    end
  endtask

  task automatic test_bad_fetch;
    logic [31:0] addrs [2];
    addrs[0] = 32'h13;
    addrs[1] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 1'b1, addrs[i], 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if ({fetch_gnt, mem_en} !== 2'b10 || mem_addr !== 6'd0) begin
        errors++;
        $display("[TB] FAIL bad_fetch_gnt %h: gnt=%b en=%b addr=%0d expected 1 0 0",
                 addrs[i], fetch_gnt, mem_en, mem_addr);
      end
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if ({fetch_rvalid, fetch_err} !== 2'b11 || fetch_rdata !== 32'h0) begin
        errors++;
        $display("[TB] FAIL bad_fetch_resp %h: rv=%b err=%b rdata=%h expected 1 1 0",
                 addrs[i], fetch_rvalid, fetch_err, fetch_rdata);
      end
    end
  endtask

  task automatic test_loader_write;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({ld_gnt, fetch_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 6'd8 ||
        mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL ld_write: ld/f/en/we=%b addr=%0d wdata=%h expected 1011 8 deadbeef",
               {ld_gnt, fetch_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 32'h12345678, 1'b0);
    checks++;
    if (mem_addr !== 6'd9 || mem_wdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL ld_write2: addr=%0d wdata=%h expected 9 12345678", mem_addr, mem_wdata);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0);
    checks++;
    if ({ld_gnt, mem_en, mem_we} !== 3'b100 || mem_wdata !== 32'h0 || mem_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL ld_oor: ld/en/we=%b addr=%0d wdata=%h expected 100 0 0",
               {ld_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_back_to_back;
    apply_stimulus(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_gnt !== 1'b1 || mem_addr !== 6'd8) begin
      errors++;
      $display("[TB] FAIL b2b_first: gnt=%b addr=%0d expected 1 8", fetch_gnt, mem_addr);
    end
    apply_stimulus(1'b0, 1'b1, 32'h24, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_gnt !== 1'b1 || mem_addr !== 6'd9 || fetch_rvalid !== 1'b1 ||
        fetch_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL b2b_second: gnt=%b addr=%0d rv=%b rdata=%h expected 1 9 1 deadbeef",
               fetch_gnt, mem_addr, fetch_rvalid, fetch_rdata);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL b2b_third: rv=%b rdata=%h expected 1 12345678", fetch_rvalid, fetch_rdata);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_fairness;
    logic [9:0] exp_f;
    exp_f = 10'h210;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'h10, 1'b1, 32'h30, 32'h100 + i, 1'b0);
      checks++;
      if (fetch_gnt !== exp_f[i] || ld_gnt !== !exp_f[i]) begin
        errors++;
        $display("[TB] FAIL fair_cycle%0d: fetch_gnt=%b ld_gnt=%b expected %b %b",
                 i, fetch_gnt, ld_gnt, exp_f[i], !exp_f[i]);
      end
      if (i == 5) begin
        checks++;
        if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h00500093) begin
          errors++;
          $display("[TB] FAIL fair_rdata: rv=%b rdata=%h expected 1 00500093",
                   fetch_rvalid, fetch_rdata);
        end
      end
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_lock;
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_pre_gnt: fetch_gnt=%b expected 1", fetch_gnt);
    end
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if ({fetch_gnt, fetch_rvalid, locked} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL lock_wait: gnt/rv/locked=%b expected 010",
               {fetch_gnt, fetch_rvalid, locked});
    end
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b1);
      checks++;
      if ({locked, fetch_gnt, ld_gnt, fetch_rvalid} !== 4'b1010 || mem_addr !== 6'd16) begin
        errors++;
        $display("[TB] FAIL lock_hold%0d: locked/f/ld/rv=%b addr=%0d expected 1010 16",
                 i, {locked, fetch_gnt, ld_gnt, fetch_rvalid}, mem_addr);
      end
    end
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({locked, fetch_gnt} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL lock_release: locked/gnt=%b expected 10", {locked, fetch_gnt});
    end
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({locked, fetch_gnt} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL lock_after: locked/gnt=%b expected 01", {locked, fetch_gnt});
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_read;
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_read_gnt: fetch_gnt=%b expected 1", fetch_gnt);
    end
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({fetch_rvalid, fetch_err, mem_en, locked, fetch_gnt, ld_gnt} !== 6'b0 ||
        fetch_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_read_during: rv/err/en/lk/f/ld=%b rdata=%h expected 0",
               {fetch_rvalid, fetch_err, mem_en, locked, fetch_gnt, ld_gnt}, fetch_rdata);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_read_after: fetch_rvalid=%b expected 0", fetch_rvalid);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_lock_enter: locked=%b expected 1", locked);
    end
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h44, 32'h1, 1'b1);
    checks++;
    if ({locked, ld_gnt, mem_en} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_lock_during: locked/ld/en=%b expected 000", {locked, ld_gnt, mem_en});
    end
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({locked, fetch_gnt} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rst_lock_arb: locked/gnt=%b expected 01", {locked, fetch_gnt});
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h00500093) begin
      errors++;
      $display("[TB] FAIL rst_lock_rdata: rv=%b rdata=%h expected 1 00500093",
               fetch_rvalid, fetch_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]     = 32'h00500093;
    mem_rdata  = 32'h0;
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    ld_req     = 1'b0;
    ld_addr    = 32'h0;
    ld_wdata   = 32'h0;
    ld_lock    = 1'b0;

    test_reset();
    test_single_fetch();
    test_bad_fetch();
    test_loader_write();
    test_back_to_back();
    test_fairness();
    test_lock();
    test_reset_mid_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 6, meaning the word-address width (64-word instruction memory).
REQ-002 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive loader grants while a fetch is pending.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fetch_req, input, 1 bit: fetch read request.
REQ-006 SHALL have port fetch_addr, input, 32 bits: byte address of the fetch.
REQ-007 SHALL have port fetch_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-008 SHALL have port fetch_rvalid, output, 1 bit: fetch data valid.
REQ-009 SHALL have port fetch_rdata, output, 32 bits: fetched instruction.
REQ-010 SHALL have port fetch_err, output, 1 bit: qualifies fetch_rvalid; misaligned or out-of-range fetch.
REQ-011 SHALL have port ld_req, input, 1 bit: loader write request.
REQ-012 SHALL have port ld_addr, input, 32 bits: loader byte address.
REQ-013 SHALL have port ld_wdata, input, 32 bits: word to write.
REQ-014 SHALL have port ld_lock, input, 1 bit: loader requests exclusive ownership.
REQ-015 SHALL have port ld_gnt, output, 1 bit: loader write performed this cycle.
REQ-016 SHALL have port locked, output, 1 bit: arbiter is in state LOCKED.
REQ-017 SHALL have memory-side ports mem_en (1), mem_we (1), mem_addr (AW), mem_wdata (32) as outputs and mem_rdata (32) as input; read data returns one cycle after mem_en with mem_we=0.

Function
REQ-018 SHALL implement FSM states ARB and LOCKED.
REQ-019 ARB: at most one grant per cycle; fetch_gnt and ld_gnt are never both 1.
REQ-020 ARB priority: loader wins, unless fetch_req=1 and burst_cnt==MAX_BURST, in which case fetch wins and burst_cnt clears.
REQ-021 burst_cnt: increments (saturating at MAX_BURST) on a loader grant while fetch_req=1; clears on any cycle without a loader grant.
REQ-022 Fetch grant with fetch_addr[1:0]==0 and fetch_addr[31:AW+2]==0: mem_en=1, mem_we=0, mem_addr=fetch_addr[AW+1:2].
REQ-023 In the following cycle: fetch_rvalid=1, fetch_rdata=mem_rdata, fetch_err=0; back-to-back fetch grants SHALL give back-to-back rvalid.
REQ-024 Fetch grant with an invalid address: no memory access; next cycle fetch_rvalid=1, fetch_err=1, fetch_rdata=0.
REQ-025 Loader grant: mem_en=1, mem_we=1, mem_addr=ld_addr[AW+1:2], mem_wdata=ld_wdata, all in the same cycle (combinational).
REQ-026 Loader grant with an invalid address: ld_gnt=1, mem_en=0; the write is dropped.
REQ-027 ARB->LOCKED when ld_lock=1 and no fetch read is outstanding; when a read is outstanding, the transition waits one cycle for its rvalid.
REQ-028 While a LOCKED request waits, fetch_gnt=0.
REQ-029 LOCKED: fetch_gnt=0; loader requests are granted every cycle.
REQ-030 LOCKED->ARB when ld_lock=0; burst_cnt clears on that transition.
REQ-031 Outputs SHALL be 0 when no grant is given: mem_en, mem_we, fetch_gnt, ld_gnt.
REQ-032 mem_addr and mem_wdata SHALL be 0 when mem_en=0.
REQ-033 fetch_rvalid is a single-cycle pulse per granted fetch; fetch_rdata and fetch_err SHALL be 0 when fetch_rvalid=0.

Reset
REQ-034 While reset=1, the FSM SHALL be ARB and burst_cnt=0.
REQ-035 While reset=1, all outputs SHALL be 0 and no grants SHALL be given.
REQ-036 Reset while a read is outstanding SHALL cancel it: no fetch_rvalid after reset.
REQ-037 Reset in LOCKED SHALL return the FSM to ARB.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding (ARB, LOCKED), the IMEM_AW=6 constant, and the address-validity check function.
REQ-039 A single sub-module, imem_addr_check, SHALL be used: combinational alignment and range check giving a valid flag and a word index.

Verification
REQ-040 Single fetch: fetch_req with addr 0x10, mem word 4 = 0x00500093 -> fetch_gnt at T, mem_addr=4 at T, fetch_rvalid with rdata 0x00500093 at T+1.
REQ-041 Fairness: ld_req and fetch_req held high for 10 cycles -> grant pattern L,L,L,L,F,L,L,L,L,F.
REQ-042 Misaligned fetch: addr 0x13 -> no mem_en; next cycle fetch_rvalid=1, fetch_err=1, rdata=0.
REQ-043 Out-of-range write: ld_addr 0x100 -> ld_gnt=1, mem_en=0.
REQ-044 Lock: ld_lock raised while a read is outstanding -> locked=1 one cycle after rvalid; fetch_req is starved until ld_lock=0, then fetch_gnt in the next cycle.
REQ-045 Reset mid-read: reset in the cycle after fetch_gnt -> fetch_rvalid=0, all outputs 0, FSM in ARB.
